// File: rtl/chan_delay_line.sv
// chan_delay_line: per-channel programmable delay line with flush on reconfiguration.
// Ports: clk, rst_n, in_valid/in_data, cfg_we/cfg_chan/cfg_delay, out_valid/out_data
// (+ evt when CHAN_DELAY_LINE_EVT_EN is defined).
module chan_delay_line #(
  parameter  int WIDTH     = 8,
  parameter  int CHANNELS  = 4,
  parameter  int MAX_DELAY = 16,
  localparam int DW        = $clog2(MAX_DELAY + 1),
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      cfg_we,
  input  logic [CW-1:0]             cfg_chan,
  input  logic [DW-1:0]             cfg_delay,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef CHAN_DELAY_LINE_EVT_EN
  ,
  output logic [CHANNELS-1:0]       evt
`endif
);

  logic [DW-1:0] w_cfg;

  // Delay 0 is meaningless for a registered output, so it becomes 1.
  always_comb begin
    w_cfg = cfg_delay;
    if (cfg_delay == '0)
      w_cfg = DW'(1);
    else if (int'(cfg_delay) > MAX_DELAY)
      w_cfg = DW'(MAX_DELAY);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Stage j holds a sample that reaches the output after j more edges.
    logic [MAX_DELAY:1] r_v;
    logic [WIDTH-1:0]   r_d [1:MAX_DELAY];
    logic [DW-1:0]      r_dly;
    logic               r_ov;
    logic [WIDTH-1:0]   r_od;
    logic               w_wr;
    logic [DW-1:0]      w_tap;
    logic               w_in_v;
    logic [WIDTH-1:0]   w_in_d;

    // Out-of-range channel numbers never match any c.
    assign w_wr   = cfg_we && (int'(cfg_chan) == c);
    assign w_tap  = w_wr ? w_cfg : r_dly;
    assign w_in_v = in_valid[c];
    assign w_in_d = in_data[c*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= '0;
        r_dly <= DW'(MAX_DELAY);
        r_ov  <= 1'b0;
        r_od  <= '0;
        for (int j = 1; j <= MAX_DELAY; j++)
          r_d[j] <= '0;
      end else begin
        r_ov <= !w_wr && r_v[1];
        if (!w_wr && r_v[1])
          r_od <= r_d[1];
        for (int j = 1; j < MAX_DELAY; j++) begin
          r_v[j] <= !w_wr && r_v[j+1];
          r_d[j] <= r_d[j+1];
        end
        r_v[MAX_DELAY] <= 1'b0;
        // Insert at the tap; no collision since older entries sit below it.
        for (int j = 1; j <= MAX_DELAY; j++) begin
          if (w_in_v && int'(w_tap) == j) begin
            r_v[j] <= 1'b1;
            r_d[j] <= w_in_d;
          end
        end
        if (w_wr)
          r_dly <= w_cfg;
      end
    end

    assign out_valid[c]                = r_ov;
    assign out_data[c*WIDTH +: WIDTH] = r_od;

`ifdef CHAN_DELAY_LINE_EVT_EN
    logic r_seen;
    logic r_evt;

    // r_od still holds the previous delivery when the compare is made.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_seen <= 1'b0;
        r_evt  <= 1'b0;
      end else begin
        r_evt <= !w_wr && r_v[1] && (!r_seen || (r_d[1] != r_od));
        if (!w_wr && r_v[1])
          r_seen <= 1'b1;
      end
    end

    assign evt[c] = r_evt;
`endif
  end

endmodule

// File: tb/tb_chan_delay_line.sv
// tb_chan_delay_line: table, directed and random checks of chan_delay_line
// against a timestamp-queue reference model.
module tb_chan_delay_line;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int MD = 16;
  localparam int DW = 5;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [CH-1:0]     in_valid;
  logic [CH*W-1:0]   in_data;
  logic              cfg_we;
  logic [CW-1:0]     cfg_chan;
  logic [DW-1:0]     cfg_delay;
  logic [CH-1:0]     out_valid;
  logic [CH*W-1:0]   out_data;
`ifdef CHAN_DELAY_LINE_EVT_EN
  logic [CH-1:0]     evt;
  logic [2:0]        b_evt;
`endif

  logic [2:0]  b_in_valid;
  logic [23:0] b_in_data;
  logic        b_cfg_we;
  logic [1:0]  b_cfg_chan;
  logic [2:0]  b_cfg_delay;
  logic [2:0]  b_out_valid;
  logic [23:0] b_out_data;

  chan_delay_line u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_we    (cfg_we),
    .cfg_chan  (cfg_chan),
    .cfg_delay (cfg_delay),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef CHAN_DELAY_LINE_EVT_EN
    ,
    .evt       (evt)
`endif
  );

  chan_delay_line #(
    .WIDTH     (8),
    .CHANNELS  (3),
    .MAX_DELAY (4)
  ) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_data   (b_in_data),
    .cfg_we    (b_cfg_we),
    .cfg_chan  (b_cfg_chan),
    .cfg_delay (b_cfg_delay),
    .out_valid (b_out_valid),
    .out_data  (b_out_data)
`ifdef CHAN_DELAY_LINE_EVT_EN
    ,
    .evt       (b_evt)
`endif
  );

  int checks;
  int errors;
  int cyc;

  int            m_d   [CH];
  int            q_due [CH][$];
  logic [W-1:0]  q_dat [CH][$];
  logic [CH-1:0] m_ov;
  logic [CH-1:0] m_evt;
  logic [CH-1:0] m_seen;
  logic [CH*W-1:0] m_od;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < CH; c++) begin
      m_d[c] = MD;
      q_due[c].delete();
      q_dat[c].delete();
    end
    m_ov   = '0;
    m_evt  = '0;
    m_seen = '0;
    m_od   = '0;
  endfunction

  task automatic drive(input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                       input logic we, input logic [CW-1:0] ch,
                       input logic [DW-1:0] dl);
    in_valid  = v;
    in_data   = d;
    cfg_we    = we;
    cfg_chan  = ch;
    cfg_delay = dl;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0, '0, '0);
  endtask

  // One clock edge: update the model with the inputs seen at the edge,
  // then compare every output.
  task automatic tick();
    logic [W-1:0] v;
    @(posedge clk);
    cyc++;
    m_ov  = '0;
    m_evt = '0;
    for (int c = 0; c < CH; c++) begin
      if (cfg_we && int'(cfg_chan) == c) begin
        q_due[c].delete();
        q_dat[c].delete();
        if (cfg_delay == 0)
          m_d[c] = 1;
        else if (int'(cfg_delay) > MD)
          m_d[c] = MD;
        else
          m_d[c] = int'(cfg_delay);
      end
      if (q_due[c].size() > 0 && q_due[c][0] == cyc) begin
        v = q_dat[c].pop_front();
        void'(q_due[c].pop_front());
        m_ov[c]  = 1'b1;
        m_evt[c] = !m_seen[c] || (v != m_od[c*W +: W]);
        m_seen[c] = 1'b1;
        m_od[c*W +: W] = v;
      end
      if (in_valid[c]) begin
        q_due[c].push_back(cyc + m_d[c]);
        q_dat[c].push_back(in_data[c*W +: W]);
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", 64'(out_data), 64'(m_od));
`ifdef CHAN_DELAY_LINE_EVT_EN
    chk("evt", 64'(evt), 64'(m_evt));
`endif
  endtask

  task automatic do_reset();
    idle();
    b_in_valid  = '0;
    b_in_data   = '0;
    b_cfg_we    = 1'b0;
    b_cfg_chan  = '0;
    b_cfg_delay = '0;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       we;
    logic [4:0] dly;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [13];
  int   first0;
  int   first1;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;

    // Channel 1, delay 3, strobes 1..8 on consecutive edges.
    for (int i = 0; i < 13; i++) begin
      tbl[i].we  = (i == 0);
      tbl[i].dly = 5'd3;
      tbl[i].v   = (i >= 1 && i <= 8);
      tbl[i].d   = 8'(i);
      tbl[i].ev  = (i >= 4 && i <= 11);
      tbl[i].ed  = (i < 4) ? 8'd0 : (i <= 11) ? 8'(i - 3) : 8'd8;
    end

    // Default delay, single strobe at edge 10.
    do_reset();
    for (int e = 1; e <= 28; e++) begin
      if (e == 10)
        drive(4'b0001, 32'h0000_00A5, 1'b0, '0, '0);
      else
        idle();
      tick();
      if (e == 26)
        chk("dflt_hit", {out_valid, out_data[7:0]}, {4'b0001, 8'hA5});
      else
        chk("dflt_quiet", 64'(out_valid), 64'd0);
    end

    // Table: back-to-back strobes with delay 3.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive({2'b00, tbl[i].v, 1'b0}, {16'h0, tbl[i].d, 8'h0},
            tbl[i].we, 2'd1, tbl[i].dly);
      tick();
      chk("tbl_valid", 64'(out_valid[1]), 64'(tbl[i].ev));
      chk("tbl_data", 64'(out_data[15:8]), 64'(tbl[i].ed));
    end

    // Reconfiguration flushes in-flight samples, keeps same-cycle strobe.
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      case (e)
        1:  drive('0, '0, 1'b1, 2'd2, 5'd8);
        20: drive(4'b0100, 32'h0055_0000, 1'b0, '0, '0);
        21: drive(4'b0100, 32'h0066_0000, 1'b0, '0, '0);
        23: drive(4'b0100, 32'h0077_0000, 1'b1, 2'd2, 5'd2);
        default: idle();
      endcase
      tick();
      if (e == 25)
        chk("flush_new", {out_valid[2], out_data[23:16]}, {1'b1, 8'h77});
      else if (e >= 22)
        chk("flush_quiet", 64'(out_valid[2]), 64'd0);
    end

    // Clamping of 0 and over-range delays.
    do_reset();
    first0 = -1;
    first1 = -1;
    for (int e = 1; e <= 24; e++) begin
      case (e)
        1: drive(4'b0001, 32'h0000_0010, 1'b1, 2'd0, 5'd0);
        2: drive(4'b0010, 32'h0000_2000, 1'b1, 2'd1, 5'(MD + 5));
        default: idle();
      endcase
      tick();
      if (out_valid[0] && first0 < 0) first0 = e;
      if (out_valid[1] && first1 < 0) first1 = e;
    end
    chk("clamp_lo", 64'(first0 - 1), 64'd1);
    chk("clamp_hi", 64'(first1 - 2), 64'd16);

    // Out-of-range cfg_chan on a 3-channel instance (delay 4).
    do_reset();
    for (int k = 0; k < 8; k++) begin
      b_in_valid = '0;
      b_in_data  = '0;
      b_cfg_we   = 1'b0;
      if (k == 0) begin
        b_in_valid = 3'b001;
        b_in_data  = 24'h00_0011;
      end
      if (k == 1) begin
        b_in_valid  = 3'b011;
        b_in_data   = 24'h00_3322;
        b_cfg_we    = 1'b1;
        b_cfg_chan  = 2'd3;
        b_cfg_delay = 3'd1;
      end
      @(posedge clk);
      #1;
      if (k == 4)
        chk("badch_0", {b_out_valid, b_out_data[7:0]}, {3'b001, 8'h11});
      else if (k == 5)
        chk("badch_1", {b_out_valid, b_out_data[15:0]}, {3'b011, 16'h3322});
      else
        chk("badch_q", 64'(b_out_valid), 64'd0);
    end
    b_cfg_we = 1'b0;

    // Mid-stream reset discards everything and restores delay 16.
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      if (e <= 4)
        drive('0, '0, 1'b1, CW'(e - 1), 5'd10);
      else if (e >= 30 && e <= 33)
        drive(4'b1111, {4{8'(e)}}, 1'b0, '0, '0);
      else
        idle();
      tick();
    end
    idle();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 36;
    while (cyc < 60) begin
      tick();
      chk("rst_quiet", 64'(out_valid), 64'd0);
    end
    first0 = -1;
    for (int e = 61; e <= 80; e++) begin
      if (e == 61)
        drive(4'b0001, 32'h0000_00C3, 1'b0, '0, '0);
      else
        idle();
      tick();
      if (out_valid[0] && first0 < 0) first0 = e;
    end
    chk("rst_delay", 64'(first0 - 61), 64'd16);

`ifdef CHAN_DELAY_LINE_EVT_EN
    // Change events on channel 3.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      case (e)
        1: drive('0, '0, 1'b1, 2'd3, 5'd1);
        3: drive(4'b1000, 32'h1000_0000, 1'b0, '0, '0);
        4: drive(4'b1000, 32'h1000_0000, 1'b0, '0, '0);
        5: drive(4'b1000, 32'h2200_0000, 1'b0, '0, '0);
        default: idle();
      endcase
      tick();
      chk("evt3", 64'(evt[3]), 64'(e == 4 || e == 6));
    end
`endif

    // Random traffic with occasional reconfiguration.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(CH'($urandom), CH*W'($urandom), ($urandom_range(0, 39) == 0),
            CW'($urandom), DW'($urandom_range(0, 21)));
      if (n % 7 == 0) in_data[7:0] = 8'h5A;
      tick();
    end
    idle();
    for (int n = 0; n < MD + 2; n++)
      tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_delay_line.md
CHAN_DELAY_LINE -- requirements
Module: chan_delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, independent channels (>=1).
REQ-003 SHALL have parameter MAX_DELAY, default 16, maximum programmable delay in cycles (>=2).
REQ-004 SHALL derive local DW = clog2(MAX_DELAY+1) and CW = max(1, clog2(CHANNELS)).
REQ-005 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel sample strobe.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
REQ-009 SHALL have port cfg_we  input  1  delay write strobe.
REQ-010 SHALL have port cfg_chan  input  CW  target channel of write.
REQ-011 SHALL have port cfg_delay  input  DW  new delay value.
REQ-012 SHALL have port out_valid  output  CHANNELS  delayed strobe, registered.
REQ-013 SHALL have port out_data  output  CHANNELS*WIDTH  delayed data, registered, same packing as in_data.

Function
REQ-014 Each channel SHALL hold its own delay register D[c]; delays SHALL be independent across channels.
REQ-015 A sample with in_valid[c]=1 at edge k SHALL appear with out_valid[c]=1 after edge k+D[c], for exactly one cycle.
REQ-016 Samples SHALL be delivered in order, one per input strobe, no drops or duplicates while D[c] is unchanged; back-to-back strobes every cycle SHALL be supported.
REQ-017 Written delay 0 SHALL be stored as 1; values above MAX_DELAY SHALL be stored as MAX_DELAY.
REQ-018 On cfg_we=1 with cfg_chan<CHANNELS, D[cfg_chan] SHALL update at that edge and all in-flight samples of that channel SHALL be discarded at that same edge.
REQ-019 A sample strobed on a channel in the same cycle as its cfg_we SHALL be kept and delivered with the new delay.
REQ-020 cfg_we with cfg_chan>=CHANNELS SHALL be ignored with no state change.
REQ-021 When out_valid[c]=0, out_data[c] SHALL hold the last delivered value.
REQ-022 Storage SHALL be per-channel MAX_DELAY-entry circular buffer or shift pipeline; any structure meeting REQ-015..REQ-021 is acceptable.

Reset
REQ-023 rst_n low SHALL asynchronously clear out_valid, out_data, all in-flight samples, and set every D[c] to MAX_DELAY.
REQ-024 Reset asserted mid-stream SHALL discard all pending samples; none SHALL emerge after deassertion.
REQ-025 The first in_valid accepted is at the first rising edge with rst_n high.

Configuration
REQ-026 Macro CHAN_DELAY_LINE_EVT_EN, when defined, SHALL add port evt  output  CHANNELS  change-event pulse.
REQ-027 With the macro, evt[c] SHALL be 1 exactly in cycles where out_valid[c]=1 and out_data[c] differs from the previous delivered value; first delivery after reset always pulses; evt resets to 0.
REQ-028 Without the macro, port evt and its compare logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Defaults, no cfg; ch0 strobe 0xA5 at edge 10 -> out_valid[0]=1, out_data[0]=0xA5 after edge 26 only; other channels idle.
REQ-030 D[1]=3, ch1 strobes 0x01..0x08 on consecutive edges 5..12 -> same values on edges 8..15, continuous out_valid[1].
REQ-031 D[2]=8, strobes at edges 20,21; cfg D[2]=2 with new strobe 0x77 at edge 23 -> earlier samples never appear; 0x77 emerges after edge 25.
REQ-032 Writes cfg_delay=0 and cfg_delay=MAX_DELAY+5 -> delays of 1 and 16 measured; cfg_chan=CHANNELS write -> no channel affected.
REQ-033 Strobes at edges 30..33 with D=10, rst_n low at edge 35, high at 37 -> out_valid stays 0 through edge 60, D back to 16.
REQ-034 With CHAN_DELAY_LINE_EVT_EN: delivered ch3 sequence 0x10,0x10,0x22 -> evt[3] pulses on first and third deliveries only.
